// File: rtl/pwm_fade_controller.sv
// Duty-cycle fade sequencer for four PWM channels: ramps each duty value toward a
// commanded target in fixed steps, paced by per-channel PWM period ticks.
module pwm_fade_controller #(
    parameter logic [7:0]  RESET_DUTY = 8'h00,
    parameter int unsigned INTERVAL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            step_tick,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_ch,
    input  logic [7:0]            cmd_target,
    input  logic [7:0]            cmd_step,
    input  logic [INTERVAL_W-1:0] cmd_interval,
    input  logic                  stop_all,
    output logic [7:0]            duty_0,
    output logic [7:0]            duty_1,
    output logic [7:0]            duty_2,
    output logic [7:0]            duty_3,
    output logic [3:0]            busy,
    output logic [3:0]            done
);

    typedef enum logic {
        S_IDLE,
        S_RAMP
    } state_e;

    localparam logic [INTERVAL_W-1:0] INTERVAL_ONE = INTERVAL_W'(1);

    state_e                state_q    [4];
    logic [7:0]            duty_q     [4];
    logic [7:0]            target_q   [4];
    logic [7:0]            step_q     [4];
    logic [INTERVAL_W-1:0] interval_q [4];
    logic [INTERVAL_W-1:0] tick_cnt_q [4];
    logic [3:0]            done_q;

    logic [7:0] stepped_d [4];
    logic       reach_d   [4];
    logic [8:0] gap_d     [4];

    assign cmd_ready = ~stop_all;

    assign duty_0 = duty_q[0];
    assign duty_1 = duty_q[1];
    assign duty_2 = duty_q[2];
    assign duty_3 = duty_q[3];
    assign done   = done_q;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            busy[i] = (state_q[i] == S_RAMP);
        end
    end

    // One step toward the target, computed with 9-bit gaps so it saturates at the target.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            stepped_d[i] = duty_q[i];
            reach_d[i]   = 1'b0;
            gap_d[i]     = '0;
            if (target_q[i] > duty_q[i]) begin
                gap_d[i] = {1'b0, target_q[i]} - {1'b0, duty_q[i]};
                if (gap_d[i] <= {1'b0, step_q[i]}) begin
                    stepped_d[i] = target_q[i];
                    reach_d[i]   = 1'b1;
                end else begin
                    stepped_d[i] = duty_q[i] + step_q[i];
                end
            end else begin
                gap_d[i] = {1'b0, duty_q[i]} - {1'b0, target_q[i]};
                if (gap_d[i] <= {1'b0, step_q[i]}) begin
                    stepped_d[i] = target_q[i];
                    reach_d[i]   = 1'b1;
                end else begin
                    stepped_d[i] = duty_q[i] - step_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i]    <= S_IDLE;
                duty_q[i]     <= RESET_DUTY;
                target_q[i]   <= '0;
                step_q[i]     <= '0;
                interval_q[i] <= '0;
                tick_cnt_q[i] <= '0;
            end
        end else begin
            done_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (stop_all) begin
                    state_q[i] <= S_IDLE;
                end else if (cmd_valid && (cmd_ch == 2'(i))) begin
                    // Accepted command wins over a same-edge step on this channel.
                    target_q[i]   <= cmd_target;
                    step_q[i]     <= cmd_step;
                    interval_q[i] <= (cmd_interval == '0) ? INTERVAL_ONE : cmd_interval;
                    tick_cnt_q[i] <= '0;
                    if (cmd_target == duty_q[i]) begin
                        state_q[i] <= S_IDLE;
                        done_q[i]  <= 1'b1;
                    end else if (cmd_step == '0) begin
                        duty_q[i]  <= cmd_target;
                        state_q[i] <= S_IDLE;
                        done_q[i]  <= 1'b1;
                    end else begin
                        state_q[i] <= S_RAMP;
                    end
                end else if ((state_q[i] == S_RAMP) && step_tick[i]) begin
                    if (tick_cnt_q[i] == (interval_q[i] - INTERVAL_ONE)) begin
                        tick_cnt_q[i] <= '0;
                        duty_q[i]     <= stepped_d[i];
                        if (reach_d[i]) begin
                            state_q[i] <= S_IDLE;
                            done_q[i]  <= 1'b1;
                        end
                    end else begin
                        tick_cnt_q[i] <= tick_cnt_q[i] + INTERVAL_ONE;
                    end
                end
            end
        end
    end

endmodule
